// File: rtl/ysyx_25060170_lsu_bus_if.sv
// Data-memory port of the LSU: single-outstanding request channel plus an
// always-accepted response channel.
interface ysyx_25060170_lsu_bus_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_req_wen;
    logic [XLEN-1:0]     mem_req_wdata;
    logic [XLEN/8-1:0]   mem_req_wstrb;
    logic                mem_resp_valid;
    logic [XLEN-1:0]     mem_resp_rdata;
    logic                mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_25060170_lsu_bus.sv
// Load/store unit between EXU and WBU: one outstanding memory transaction,
// lane steering, load extension, misalign/bus-error/timeout detection.
module ysyx_25060170_lsu_bus #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    output logic                     ls_ready,
    input  logic [XLEN-1:0]          alu_res,
    input  logic [XLEN-1:0]          store_data,
    input  logic                     ls_load,
    input  logic                     ls_store,
    input  logic [1:0]               ls_size,
    input  logic                     ls_unsigned,
    ysyx_25060170_lsu_bus_if.master  mem,
    output logic                     ls_valid,
    input  logic                     wb_ready,
    output logic [XLEN-1:0]          ls_data_o,
    output logic [1:0]               ls_exc
);
    localparam int unsigned NB      = XLEN / 8;
    localparam int unsigned OFF_W   = $clog2(NB);
    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              req_valid_q, req_valid_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [1:0]        exc_q, exc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [OFF_W-1:0]  off_q, off_d;

    logic              accept, is_mem, illegal, misaligned;
    logic [OFF_W-1:0]  off, align_mask;
    logic [NB-1:0]     strb_base;
    logic [XLEN-1:0]   wdata_base;
    logic [XLEN-1:0]   rshift, ld_mask, ld_val;
    logic              ld_sign;

    assign ls_ready   = (state == S_IDLE) || ((state == S_HOLD) && wb_ready);
    assign accept     = ex_valid && ls_ready;
    assign is_mem     = ls_load || ls_store;
    assign off        = alu_res[OFF_W-1:0];
    assign illegal    = ((XLEN == 32) && (ls_size == 2'b11)) || (ls_load && ls_store);
    assign misaligned = (off & align_mask) != '0;

    // Size decode for the incoming instruction: alignment mask and unshifted lanes
    always_comb begin : lane_decode
        align_mask = '0;
        strb_base  = '0;
        wdata_base = '0;
        case (ls_size)
            2'b00: begin
                align_mask = OFF_W'(0);
                strb_base  = NB'(1);
                wdata_base = XLEN'(store_data[7:0]);
            end
            2'b01: begin
                align_mask = OFF_W'(1);
                strb_base  = NB'(2'b11);
                wdata_base = XLEN'(store_data[15:0]);
            end
            2'b10: begin
                align_mask = OFF_W'(3);
                strb_base  = NB'(4'hF);
                wdata_base = XLEN'(store_data[31:0]);
            end
            default: begin
                align_mask = OFF_W'(7);
                strb_base  = NB'(8'hFF);
                wdata_base = store_data;
            end
        endcase
    end

    // Load result: move the addressed lane to bit 0, then truncate and extend
    assign rshift = mem.mem_resp_rdata >> {off_q, 3'b000};

    always_comb begin : load_extend
        ld_mask = '1;
        ld_sign = 1'b0;
        case (size_q)
            2'b00:   begin ld_mask = XLEN'(8'hFF);         ld_sign = rshift[7];  end
            2'b01:   begin ld_mask = XLEN'(16'hFFFF);      ld_sign = rshift[15]; end
            2'b10:   begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = rshift[31]; end
            default: begin ld_mask = '1;                   ld_sign = 1'b0;       end
        endcase
        ld_val = (rshift & ld_mask) | ((ld_sign && !uns_q) ? ~ld_mask : '0);
    end

    always_comb begin : next_state
        state_d = state;
        cnt_d   = cnt;
        data_d  = data_q;
        exc_d   = exc_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;

        case (state)
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end
            end
            S_RESP: begin
                if (mem.mem_resp_valid) begin
                    state_d = S_HOLD;
                    exc_d   = mem.mem_resp_err ? 2'b10 : 2'b00;
                    data_d  = (mem.mem_resp_err || wen_q) ? '0 : ld_val;
                end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST))) begin
                    state_d = S_HOLD;
                    exc_d   = 2'b10;
                    data_d  = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (wb_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        // Accept overrides the HOLD->IDLE exit so back-to-back issue works
        if (accept) begin
            if (!is_mem) begin
                state_d = S_HOLD;
                data_d  = alu_res;
                exc_d   = 2'b00;
            end else if (illegal) begin
                state_d = S_HOLD;
                data_d  = '0;
                exc_d   = 2'b11;
            end else if (misaligned) begin
                state_d = S_HOLD;
                data_d  = '0;
                exc_d   = 2'b01;
            end else begin
                state_d = S_REQ;
                addr_d  = ADDR_W'(alu_res) & ~ADDR_W'(NB - 1);
                wen_d   = ls_store;
                wdata_d = ls_store ? (wdata_base << {off, 3'b000}) : '0;
                wstrb_d = ls_store ? (strb_base << off) : '0;
                size_d  = ls_size;
                uns_d   = ls_unsigned;
                off_d   = off;
            end
        end

        req_valid_d = (state_d == S_REQ);
        valid_d     = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            exc_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            req_valid_q <= req_valid_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            exc_q       <= exc_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = addr_q;
    assign mem.mem_req_wen   = wen_q;
    assign mem.mem_req_wdata = wdata_q;
    assign mem.mem_req_wstrb = wstrb_q;
    assign ls_valid          = valid_q;
    assign ls_data_o         = data_q;
    assign ls_exc            = exc_q;
endmodule

// File: tb/tb_ysyx_25060170_lsu_bus.sv
// Bench for the LSU: a 32-bit and a 64-bit instance (both TIMEOUT=4) share
// stimulus; sel64 picks which one is driven and observed.
module tb_ysyx_25060170_lsu_bus;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel64, ex_valid, ls_load, ls_store, ls_unsigned, wb_ready;
    logic        req_ready, resp_valid, resp_err;
    logic [1:0]  ls_size;
    logic [63:0] alu_res, store_data, resp_rdata;

    logic        r32, v32, r64, v64;
    logic [31:0] d32;
    logic [63:0] d64;
    logic [1:0]  e32, e64;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_25060170_lsu_bus_if #(.XLEN(32), .ADDR_W(32)) m32 ();
    ysyx_25060170_lsu_bus_if #(.XLEN(64), .ADDR_W(32)) m64 ();

    assign m32.mem_req_ready  = req_ready;
    assign m32.mem_resp_valid = resp_valid;
    assign m32.mem_resp_rdata = resp_rdata[31:0];
    assign m32.mem_resp_err   = resp_err;
    assign m64.mem_req_ready  = req_ready;
    assign m64.mem_resp_valid = resp_valid;
    assign m64.mem_resp_rdata = resp_rdata;
    assign m64.mem_resp_err   = resp_err;

    ysyx_25060170_lsu_bus #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid && !sel64), .ls_ready(r32),
        .alu_res(alu_res[31:0]), .store_data(store_data[31:0]),
        .ls_load(ls_load), .ls_store(ls_store), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .mem(m32), .ls_valid(v32), .wb_ready(wb_ready), .ls_data_o(d32), .ls_exc(e32)
    );

    ysyx_25060170_lsu_bus #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) dut64 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid && sel64), .ls_ready(r64),
        .alu_res(alu_res), .store_data(store_data),
        .ls_load(ls_load), .ls_store(ls_store), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .mem(m64), .ls_valid(v64), .wb_ready(wb_ready), .ls_data_o(d64), .ls_exc(e64)
    );

    wire        o_ready     = sel64 ? r64 : r32;
    wire        o_valid     = sel64 ? v64 : v32;
    wire [63:0] o_data      = sel64 ? d64 : {32'd0, d32};
    wire [1:0]  o_exc       = sel64 ? e64 : e32;
    wire        o_req_valid = sel64 ? m64.mem_req_valid : m32.mem_req_valid;
    wire [31:0] o_addr      = sel64 ? m64.mem_req_addr : m32.mem_req_addr;
    wire        o_wen       = sel64 ? m64.mem_req_wen : m32.mem_req_wen;
    wire [63:0] o_wdata     = sel64 ? m64.mem_req_wdata : {32'd0, m32.mem_req_wdata};
    wire [7:0]  o_wstrb     = sel64 ? m64.mem_req_wstrb : {4'd0, m32.mem_req_wstrb};

    // Reference: what the access should look like, from byte arithmetic on the address
    function automatic void model(
        input bit is64, input bit ld, input bit st, input logic [1:0] sz, input bit uns,
        input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd, input bit er,
        output bit gb, output logic [1:0] exc, output logic [63:0] data,
        output logic [31:0] addr, output logic [63:0] wdata, output logic [7:0] wstrb);
        int unsigned xb, bytes, off;
        logic [127:0] one, xmask, lim, t;
        xb    = is64 ? 8 : 4;
        bytes = 32'd1 << sz;
        off   = 32'(a % 64'(xb));
        one   = 128'd1;
        xmask = (one << (8 * xb)) - one;
        lim   = one << (8 * bytes);
        gb = 1'b0; exc = 2'b00; data = '0; addr = '0; wdata = '0; wstrb = '0;
        if (!ld && !st) begin
            data = 64'({64'd0, a} & xmask);
        end else if ((!is64 && sz == 2'b11) || (ld && st)) begin
            exc = 2'b11;
        end else if (a % 64'(bytes) != 64'd0) begin
            exc = 2'b01;
        end else begin
            gb   = 1'b1;
            addr = a[31:0] - 32'(off);
            if (st) begin
                wstrb = 8'(((one << bytes) - one) << off);
                wdata = 64'(({64'd0, sd} % lim) << (8 * off));
            end else begin
                t = ({64'd0, rd} & xmask) >> (8 * off);
                t = t % lim;
                if (!uns && t >= (lim >> 1)) t = t + (one << (8 * xb)) - lim;
                data = 64'(t & xmask);
            end
            if (er) begin
                exc  = 2'b10;
                data = '0;
            end
        end
    endfunction

    task automatic run_op(input bit s64, input bit ld, input bit st, input logic [1:0] sz,
                          input bit uns, input logic [63:0] a, input logic [63:0] sd,
                          input logic [63:0] rd, input bit er,
                          input int rdly, input int pdly, input int wdly);
        bit gb;
        logic [1:0]  ex;
        logic [63:0] dat, wd;
        logic [31:0] ad;
        logic [7:0]  ws;
        model(s64, ld, st, sz, uns, a, sd, rd, er, gb, ex, dat, ad, wd, ws);
        @(negedge clk);
        sel64 = s64; ls_load = ld; ls_store = st; ls_size = sz; ls_unsigned = uns;
        alu_res = a; store_data = sd; ex_valid = 1'b1; wb_ready = 1'b0; req_ready = 1'b0;
        #1;
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_idle: got %b want 1", o_ready);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        if (gb) begin
            for (int i = 0; i <= rdly; i++) begin
                n_tests++;
                if (o_req_valid !== 1'b1 || o_addr !== ad || o_wen !== st ||
                    o_wdata !== wd || o_wstrb !== ws) begin
                    n_fail++;
                    $display("FAIL req_fields: got v=%b a=%h we=%b wd=%h ws=%h want v=1 a=%h we=%b wd=%h ws=%h",
                             o_req_valid, o_addr, o_wen, o_wdata, o_wstrb, ad, st, wd, ws);
                end
                if (i == rdly) req_ready = 1'b1;
                @(negedge clk);
            end
            req_ready = 1'b0;
            n_tests++;
            if (o_req_valid !== 1'b0 || o_valid !== 1'b0) begin
                n_fail++; $display("FAIL req_drop: got req=%b valid=%b want 0 0", o_req_valid, o_valid);
            end
            for (int i = 0; i < pdly; i++) @(negedge clk);
            resp_valid = 1'b1; resp_rdata = rd; resp_err = er;
            @(negedge clk);
            resp_valid = 1'b0; resp_err = 1'b0;
        end
        for (int i = 0; i <= wdly; i++) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_exc !== ex || o_req_valid !== 1'b0 ||
                (ex != 2'b01 && ex != 2'b11 && o_data !== dat)) begin
                n_fail++;
                $display("FAIL hold_result: got v=%b exc=%b data=%h req=%b want v=1 exc=%b data=%h req=0",
                         o_valid, o_exc, o_data, o_req_valid, ex, dat);
            end
            if (i == wdly) wb_ready = 1'b1;
            @(negedge clk);
        end
        wb_ready = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL back_idle: got valid=%b ready=%b want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #1;
            n_tests++;
            if (o_valid !== 1'b0 || o_req_valid !== 1'b0 || o_exc !== 2'b00 || o_data !== 64'd0 ||
                o_addr !== 32'd0 || o_wen !== 1'b0 || o_wdata !== 64'd0 || o_wstrb !== 8'd0 ||
                o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s: sel64=%0d got v=%b req=%b exc=%b d=%h a=%h we=%b wd=%h ws=%h rdy=%b want all 0, rdy 1",
                         tag, s, o_valid, o_req_valid, o_exc, o_data, o_addr, o_wen, o_wdata, o_wstrb, o_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b1;
    endtask

    task automatic test_lb32();
        run_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 64'h8000_0003, 64'h0, 64'h80AA_BBCC, 1'b0, 0, 1, 1);
    endtask

    task automatic test_sh64();
        run_op(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 64'h0000_0000_8000_0006, 64'h1234, 64'h0, 1'b0, 3, 0, 0);
    endtask

    task automatic test_exceptions();
        run_op(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 64'h8000_0002, 64'h0, 64'h0, 1'b0, 0, 0, 0);
        run_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 64'h0000_0000_8000_0002, 64'h0, 64'h0, 1'b0, 0, 0, 1);
        run_op(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 64'h8000_0000, 64'h0, 64'h0, 1'b0, 0, 0, 0);
        run_op(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 1'b0, 0, 0, 0);
        run_op(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 64'h0000_0000_8000_0008, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 0, 2, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            bit s, ld, st, uns, er;
            logic [1:0]  sz;
            logic [63:0] a, sd, rd;
            int kind;
            s    = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            ld   = (kind == 1) || (kind >= 2 && kind < 6);
            st   = (kind == 1) || (kind >= 6);
            sz   = 2'($urandom_range(0, 3));
            if (!s && sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'b10;
            a    = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            uns  = 1'($urandom_range(0, 1));
            sd   = {$urandom(), $urandom()};
            rd   = {$urandom(), $urandom()};
            er   = ($urandom_range(0, 7) == 0);
            run_op(s, ld, st, sz, uns, a, sd, rd, er,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        sel64 = 1'b1; ls_load = 1'b1; ls_store = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0;
        alu_res = 64'h0000_0000_1000_0010; ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (o_valid !== 1'b0) begin
                n_fail++; $display("FAIL timeout_early: cycle %0d got valid=%b want 0", i, o_valid);
            end
        end
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b1 || o_exc !== 2'b10 || o_data !== 64'd0) begin
            n_fail++; $display("FAIL timeout_fire: got v=%b exc=%b d=%h want 1 10 0", o_valid, o_exc, o_data);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        resp_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_stray: got v=%b rdy=%b req=%b want 0 1 0", o_valid, o_ready, o_req_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a_val, b_val;
        a_val = {$urandom(), $urandom()};
        b_val = {$urandom(), $urandom()};
        @(negedge clk);
        sel64 = 1'b1; ls_load = 1'b0; ls_store = 1'b0; alu_res = a_val; ex_valid = 1'b1; wb_ready = 1'b0;
        @(negedge clk);
        alu_res = b_val;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== a_val) begin
                n_fail++; $display("FAIL b2b_stall: got rdy=%b v=%b d=%h want 0 1 %h", o_ready, o_valid, o_data, a_val);
            end
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b want 1", o_ready);
        end
        @(negedge clk);
        ex_valid = 1'b0; wb_ready = 1'b0;
        n_tests++;
        if (o_valid !== 1'b1 || o_data !== b_val || o_exc !== 2'b00) begin
            n_fail++; $display("FAIL b2b_next: got v=%b d=%h exc=%b want 1 %h 00", o_valid, o_data, o_exc, b_val);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        sel64 = 1'b0; ls_load = 1'b0; ls_store = 1'b1; ls_size = 2'b10;
        alu_res = 64'h1234_5678; store_data = 64'hCAFE_F00D; ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_all_zero("reset_in_resp");
        sel64 = 1'b0; resp_valid = 1'b1; resp_rdata = 64'hFFFF_FFFF;
        @(negedge clk);
        resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                n_fail++; $display("FAIL reset_stray: got v=%b rdy=%b want 0 1", o_valid, o_ready);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0; sel64 = 1'b0; ex_valid = 1'b0; ls_load = 1'b0; ls_store = 1'b0;
        ls_size = 2'b00; ls_unsigned = 1'b0; wb_ready = 1'b0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_err = 1'b0; alu_res = '0; store_data = '0; resp_rdata = '0;
        test_reset();
        test_lb32();
        test_sh64();
        test_exceptions();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_in_resp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
